alu_cmd_seq: RTL and testbench

- Upstream command sequencer for the ALU datapath.
- Accepts ALU commands on a valid/ready stream and buffers them in a small command FIFO.
- Issues one command at a time to the ALU (alu_enable/alu_in1/alu_in2/alu_op), waits for alu_ready, then captures alu_out/alu_status.
- Presents each result on a valid/ready result stream, in order, one command in flight.

---
 rtl/alu_cmd_seq.sv | 185 ++++++++++++++++++
 tb/tb_alu_cmd_seq.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_seq.sv
// alu_cmd_seq: command sequencer in front of the ALU datapath.
// Commands arrive on a valid/ready stream into a small FIFO. A four-state FSM
// issues them one at a time to the ALU, waits for alu_ready, and returns each
// result, in order, on a valid/ready result stream.
// Optional feature macro: ALU_SEQ_TIMEOUT_EN. When defined, a WAIT that lasts
// TIMEOUT_CYC cycles is aborted with res_err=1. When undefined, WAIT never
// times out and res_err is tied 0.
//
// Handshake rule for both streams: a transfer happens on a rising edge where
// valid and ready are both 1. valid does not wait for ready. Once valid is
// raised, its payload stays stable until the transfer. cmd_ready depends only
// on the FIFO count, and res_valid depends only on the FSM state.
module alu_cmd_seq #(
  parameter int CMD_DEPTH   = 4,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [7:0] cmd_in1,
  input  logic [7:0] cmd_in2,
  input  logic [4:0] cmd_op,
  output logic       alu_enable,
  output logic [7:0] alu_in1,
  output logic [7:0] alu_in2,
  output logic [4:0] alu_op,
  input  logic [7:0] alu_out,
  input  logic [4:0] alu_status,
  input  logic       alu_ready,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [7:0] res_data,
  output logic [4:0] res_status,
  output logic       res_err,
  output logic       busy
);

  localparam int PW = $clog2(CMD_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t        state_q, state_d;
  logic [20:0]   mem_q [CMD_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [7:0]    in1_q, in1_d, in2_q, in2_d;
  logic [4:0]    op_q, op_d;
  logic [7:0]    rdata_q, rdata_d;
  logic [4:0]    rstat_q, rstat_d;
  logic          push, pop;

`ifdef ALU_SEQ_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic          rerr_q, rerr_d;
`else
  logic          unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYC < 2);
`endif

  assign cmd_ready  = (count_q != CW'(CMD_DEPTH));
  assign push       = cmd_valid & cmd_ready;
  assign alu_enable = (state_q == S_ISSUE);
  assign res_valid  = (state_q == S_RESP);
  assign alu_in1    = in1_q;
  assign alu_in2    = in2_q;
  assign alu_op     = op_q;
  assign res_data   = rdata_q;
  assign res_status = rstat_q;
  assign busy       = (count_q != '0) | (state_q != S_IDLE);
`ifdef ALU_SEQ_TIMEOUT_EN
  assign res_err    = rerr_q;
`else
  assign res_err    = 1'b0;
`endif

  // FIFO pointer/count update; a push and a pop in the same cycle cancel.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Sequencer FSM: pop in IDLE, strobe in ISSUE, capture in WAIT, hold in RESP.
  always_comb begin
    state_d = state_q;
    in1_d   = in1_q;
    in2_d   = in2_q;
    op_d    = op_q;
    rdata_d = rdata_q;
    rstat_d = rstat_q;
    pop     = 1'b0;
`ifdef ALU_SEQ_TIMEOUT_EN
    tcnt_d  = tcnt_q;
    rerr_d  = rerr_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (count_q != '0) begin
          pop                  = 1'b1;
          {op_d, in2_d, in1_d} = mem_q[rd_ptr_q];
          state_d              = S_ISSUE;
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
`ifdef ALU_SEQ_TIMEOUT_EN
        tcnt_d  = '0;
`endif
      end
      S_WAIT: begin
        if (alu_ready) begin
          rdata_d = alu_out;
          rstat_d = alu_status;
`ifdef ALU_SEQ_TIMEOUT_EN
          rerr_d  = 1'b0;
`endif
          state_d = S_RESP;
        end
`ifdef ALU_SEQ_TIMEOUT_EN
        else if (tcnt_q == TW'(TIMEOUT_CYC - 1)) begin
          rdata_d = '0;
          rstat_d = '0;
          rerr_d  = 1'b1;
          state_d = S_RESP;
        end else begin
          tcnt_d = tcnt_q + TW'(1);
        end
`endif
      end
      S_RESP: begin
        if (res_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Command storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {cmd_op, cmd_in2, cmd_in1};
  end

  // State, pointers, operand and result registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      in1_q    <= '0;
      in2_q    <= '0;
      op_q     <= '0;
      rdata_q  <= '0;
      rstat_q  <= '0;
`ifdef ALU_SEQ_TIMEOUT_EN
      tcnt_q   <= '0;
      rerr_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      in1_q    <= in1_d;
      in2_q    <= in2_d;
      op_q     <= op_d;
      rdata_q  <= rdata_d;
      rstat_q  <= rstat_d;
`ifdef ALU_SEQ_TIMEOUT_EN
      tcnt_q   <= tcnt_d;
      rerr_q   <= rerr_d;
`endif
    end
  end

endmodule

// File: tb/tb_alu_cmd_seq.sv
// tb_alu_cmd_seq: directed bench for alu_cmd_seq with a table of commands and
// hand-computed results, plus hand-written multi-cycle sequences.
// The bench ALU returns out = in1 + in2 (mod 256) and status = op.
module tb_alu_cmd_seq;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid, cmd_ready;
  logic [7:0] cmd_in1, cmd_in2;
  logic [4:0] cmd_op;
  logic       alu_enable;
  logic [7:0] alu_in1, alu_in2;
  logic [4:0] alu_op;
  logic [7:0] alu_out;
  logic [4:0] alu_status;
  logic       alu_ready;
  logic       res_valid, res_ready;
  logic [7:0] res_data;
  logic [4:0] res_status;
  logic       res_err, busy;

  alu_cmd_seq #(.CMD_DEPTH(4), .TIMEOUT_CYC(16)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_in1(cmd_in1), .cmd_in2(cmd_in2), .cmd_op(cmd_op),
    .alu_enable(alu_enable), .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_op(alu_op),
    .alu_out(alu_out), .alu_status(alu_status), .alu_ready(alu_ready),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_status(res_status), .res_err(res_err),
    .busy(busy)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int total = 0;
  int bad   = 0;
  logic [13:0] exp_q[$];   // {err, status[4:0], data[7:0]}

  // ALU responder controls
  bit alu_auto = 1'b0;
  int alu_lat  = 3;
  int man_req  = 0;
  int man_done = 0;

  typedef struct {
    logic [7:0] in1;
    logic [7:0] in2;
    logic [4:0] op;
    logic [7:0] exp_data;
    logic [4:0] exp_status;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_cmd(input logic [7:0] a, input logic [7:0] b, input logic [4:0] o,
                          input logic [13:0] exp_word);
    int guard = 0;
    cmd_in1   = a;
    cmd_in2   = b;
    cmd_op    = o;
    cmd_valid = 1'b1;
    while (!cmd_ready && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!cmd_ready) begin
      total++;
      bad++;
      $display("FAIL push_timeout: cmd_ready stayed 0 for %0d cycles", guard);
    end else begin
      exp_q.push_back(exp_word);
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int guard = 0;
    while ((exp_q.size() != 0 || busy) && guard < 500) begin
      @(posedge clk); #1;
      guard++;
    end
    chk({name, "_pending"}, exp_q.size(), 0);
    chk({name, "_busy"}, busy, 1'b0);
  endtask

  // ---------------- ALU model ----------------
  initial begin
    alu_ready  = 1'b0;
    alu_out    = '0;
    alu_status = '0;
    forever begin
      @(posedge clk); #2;
      if (man_req != man_done) begin
        man_done++;
        alu_out    = alu_in1 + alu_in2;
        alu_status = alu_op;
        alu_ready  = 1'b1;
        @(posedge clk); #2;
        alu_ready  = 1'b0;
      end else if (alu_auto && alu_enable && !reset) begin
        repeat (alu_lat) @(posedge clk);
        #2;
        alu_out    = alu_in1 + alu_in2;
        alu_status = alu_op;
        alu_ready  = 1'b1;
        @(posedge clk); #2;
        alu_ready  = 1'b0;
      end
    end
  end

  // ---------------- result monitor ----------------
  logic [13:0] hold_v;
  bit          hold_ok = 1'b0;
  initial begin
    logic [13:0] e;
    forever begin
      @(negedge clk);
      if (reset) begin
        hold_ok = 1'b0;
      end else if (res_valid) begin
        if (hold_ok) chk("res_hold", {res_err, res_status, res_data}, hold_v);
        if (res_ready) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL res_unexpected: data=%0h status=%0h err=%0b with nothing expected",
                     res_data, res_status, res_err);
          end else begin
            e = exp_q.pop_front();
            chk("res_data", res_data, e[7:0]);
            chk("res_status", res_status, e[12:8]);
            chk("res_err", res_err, e[13]);
          end
          hold_ok = 1'b0;
        end else begin
          hold_v  = {res_err, res_status, res_data};
          hold_ok = 1'b1;
        end
      end else begin
        hold_ok = 1'b0;
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- main sequence ----------------
  initial begin
    // command table; results run 0..9, status equals op
    vecs[0] = '{8'h00, 8'h00, 5'h00, 8'h00, 5'h00};
    vecs[1] = '{8'h01, 8'h00, 5'h01, 8'h01, 5'h01};
    vecs[2] = '{8'hFF, 8'h03, 5'h02, 8'h02, 5'h02};
    vecs[3] = '{8'h80, 8'h83, 5'h03, 8'h03, 5'h03};
    vecs[4] = '{8'h02, 8'h02, 5'h04, 8'h04, 5'h04};
    vecs[5] = '{8'hF0, 8'h15, 5'h05, 8'h05, 5'h05};
    vecs[6] = '{8'h03, 8'h03, 5'h1F, 8'h06, 5'h1F};
    vecs[7] = '{8'h07, 8'h00, 5'h10, 8'h07, 5'h10};
    vecs[8] = '{8'h7F, 8'h89, 5'h08, 8'h08, 5'h08};
    vecs[9] = '{8'h04, 8'h05, 5'h11, 8'h09, 5'h11};

    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_in1   = '0;
    cmd_in2   = '0;
    cmd_op    = '0;
    res_ready = 1'b0;

    // reset values
    repeat (2) @(posedge clk);
    #1;
    chk("rst_cmd_ready", cmd_ready, 1'b1);
    chk("rst_alu_enable", alu_enable, 1'b0);
    chk("rst_alu_ops", {alu_op, alu_in2, alu_in1}, 21'h0);
    chk("rst_res_valid", res_valid, 1'b0);
    chk("rst_res_payload", {res_err, res_status, res_data}, 14'h0);
    chk("rst_busy", busy, 1'b0);
    reset = 1'b0;
    @(posedge clk); #1;

    // single command: latency and strobe width
    alu_auto  = 1'b1;
    alu_lat   = 3;
    res_ready = 1'b1;
    exp_q.push_back({1'b0, 5'h00, 8'h08});
    cmd_in1 = 8'h05; cmd_in2 = 8'h03; cmd_op = 5'h00; cmd_valid = 1'b1;   // cycle N
    chk("single_cmd_ready", cmd_ready, 1'b1);
    @(posedge clk); #1; cmd_valid = 1'b0;                                   // N+1
    chk("single_en_n1", alu_enable, 1'b0);
    chk("single_busy_n1", busy, 1'b1);
    @(posedge clk); #1;                                                     // N+2
    chk("single_en_n2", alu_enable, 1'b1);
    chk("single_ops_n2", {alu_op, alu_in2, alu_in1}, {5'h00, 8'h03, 8'h05});
    @(posedge clk); #1;                                                     // N+3
    chk("single_en_n3", alu_enable, 1'b0);
    @(posedge clk); #1;                                                     // N+4
    chk("single_rv_n4", res_valid, 1'b0);
    @(posedge clk); #1;                                                     // N+5: alu_ready
    chk("single_rv_n5", res_valid, 1'b0);
    @(posedge clk); #1;                                                     // N+6
    chk("single_rv_n6", res_valid, 1'b1);
    chk("single_data_n6", res_data, 8'h08);
    chk("single_ops_n6", {alu_op, alu_in2, alu_in1}, {5'h00, 8'h03, 8'h05});
    @(posedge clk); #1;                                                     // N+7
    chk("single_rv_n7", res_valid, 1'b0);
    chk("single_busy_n7", busy, 1'b0);

    // table: back-to-back pushes, simultaneous push/pop, pointer wrap
    alu_lat = 1;
    for (int i = 0; i < 10; i++)
      push_cmd(vecs[i].in1, vecs[i].in2, vecs[i].op, {1'b0, vecs[i].exp_status, vecs[i].exp_data});
    wait_drain("table");

    // FIFO full with both ALU and consumer stalled
    alu_auto  = 1'b0;
    res_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      push_cmd(8'((i + 1) * 16), 8'(i + 1), 5'(i + 1), {1'b0, 5'(i + 1), 8'((i + 1) * 17)});
      chk($sformatf("full_ready_%0d", i), cmd_ready, (i == 4) ? 1'b0 : 1'b1);
    end
    cmd_in1 = 8'h99; cmd_in2 = 8'h99; cmd_op = 5'h19; cmd_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk($sformatf("full_hold_ready_%0d", i), cmd_ready, 1'b0);
    end
    cmd_valid = 1'b0;
    chk("full_first_ops", {alu_op, alu_in2, alu_in1}, {5'h01, 8'h01, 8'h10});
    man_req++;
    @(posedge clk); #1;
    chk("full_first_rv", res_valid, 1'b1);
    chk("full_first_data", res_data, 8'h11);
    alu_lat   = 2;
    alu_auto  = 1'b1;
    res_ready = 1'b1;
    wait_drain("full");

    // result backpressure for 10 cycles in RESP
    alu_lat   = 1;
    res_ready = 1'b0;
    push_cmd(8'h21, 8'h12, 5'h0A, {1'b0, 5'h0A, 8'h33});
    begin
      int g = 0;
      while (!res_valid && g < 50) begin
        @(posedge clk); #1;
        g++;
      end
    end
    chk("bp_reached_resp", res_valid, 1'b1);
    push_cmd(8'h01, 8'h01, 5'h01, {1'b0, 5'h01, 8'h02});
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk($sformatf("bp_rv_%0d", i), res_valid, 1'b1);
      chk($sformatf("bp_data_%0d", i), {res_status, res_data}, {5'h0A, 8'h33});
      chk($sformatf("bp_en_%0d", i), alu_enable, 1'b0);
    end
    res_ready = 1'b1;                                                       // handshake at K
    @(posedge clk); #1;                                                     // K+1
    chk("bp_en_k1", alu_enable, 1'b0);
    chk("bp_rv_k1", res_valid, 1'b0);
    @(posedge clk); #1;                                                     // K+2
    chk("bp_en_k2", alu_enable, 1'b1);
    chk("bp_ops_k2", {alu_op, alu_in2, alu_in1}, {5'h01, 8'h01, 8'h01});
    wait_drain("bp");

    // reset in WAIT with three commands queued
    alu_auto = 1'b0;
    for (int i = 0; i < 4; i++)
      push_cmd(8'h40 + 8'(i), 8'h01, 5'h07, 14'h0);
    @(posedge clk); #1;
    chk("rw_busy_before", busy, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    chk("rw_cmd_ready", cmd_ready, 1'b1);
    chk("rw_alu_enable", alu_enable, 1'b0);
    chk("rw_alu_ops", {alu_op, alu_in2, alu_in1}, 21'h0);
    chk("rw_res_valid", res_valid, 1'b0);
    chk("rw_res_payload", {res_err, res_status, res_data}, 14'h0);
    chk("rw_busy", busy, 1'b0);
    exp_q.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    man_req++;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk($sformatf("rw_post_rv_%0d", i), res_valid, 1'b0);
      chk($sformatf("rw_post_busy_%0d", i), busy, 1'b0);
      chk($sformatf("rw_post_en_%0d", i), alu_enable, 1'b0);
    end

`ifdef ALU_SEQ_TIMEOUT_EN
    // timeout abort, late alu_ready ignored, then normal issue
    alu_auto  = 1'b0;
    res_ready = 1'b0;
    push_cmd(8'h11, 8'h22, 5'h03, {1'b1, 5'h00, 8'h00});
    @(posedge clk); #1;                                                     // E
    chk("to_enable", alu_enable, 1'b1);
    for (int i = 1; i <= 16; i++) begin
      @(posedge clk); #1;                                                   // E+1 .. E+16
      chk($sformatf("to_wait_rv_%0d", i), res_valid, 1'b0);
    end
    @(posedge clk); #1;                                                     // E+17
    chk("to_rv", res_valid, 1'b1);
    chk("to_err", res_err, 1'b1);
    chk("to_data", {res_status, res_data}, 13'h0);
    man_req++;
    @(posedge clk); #1;
    chk("to_late_err", res_err, 1'b1);
    chk("to_late_data", res_data, 8'h00);
    res_ready = 1'b1;
    @(posedge clk); #1;
    man_req++;
    @(posedge clk); #1;
    chk("to_idle_rv", res_valid, 1'b0);
    chk("to_idle_busy", busy, 1'b0);
    alu_auto = 1'b1;
    push_cmd(8'h0C, 8'h0D, 5'h02, {1'b0, 5'h02, 8'h19});
    wait_drain("to_next");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
